// File: rtl/uart_echo_pkg.sv
// Shared definitions for the UART echo engine: mode codes, FSM states and
// the ASCII bounds used by the upper-case transform.
package uart_echo_pkg;

    typedef enum logic [1:0] {
        MODE_PASS    = 2'd0,
        MODE_LINE    = 2'd1,
        MODE_CASE    = 2'd2,
        MODE_DISCARD = 2'd3
    } mode_e;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_DRAIN   = 1'b1
    } state_e;

    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
    localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

    function automatic logic [7:0] to_upper(input logic [7:0] b);
        if (b >= ASCII_LOWER_A && b <= ASCII_LOWER_Z)
            return b & ~ASCII_CASE_BIT;
        return b;
    endfunction

endpackage

// File: rtl/axis_uart_echo_engine_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry one extra wrap
// bit so full and empty are distinguished without a separate counter.
module sync_fifo_fwft #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign wr_ok   = wr_en & ~full;
    assign rd_ok   = rd_en & ~empty;

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_ok)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/axis_uart_echo_engine.sv
// Buffered RX-to-TX echo path with PASS/LINE/CASE/DISCARD modes and
// saturating traffic counters for bring-up over the FTDI link.
module axis_uart_echo_engine
    import uart_echo_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter int                DEPTH  = 16,
    parameter logic [DATA_W-1:0] EOL    = DATA_W'(8'h0D),
    parameter int                CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic [DATA_W-1:0]      i_tdata,
    input  logic                   i_tvalid,
    output logic                   i_tready,
    output logic [DATA_W-1:0]      o_tdata,
    output logic                   o_tvalid,
    input  logic                   o_tready,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       rx_count,
    output logic [CNT_W-1:0]       tx_count,
    output logic [CNT_W-1:0]       drop_count
);

    localparam int LW = $clog2(DEPTH) + 1;

    state_e            state;
    mode_e             act_mode;
    logic              in_en;
    logic              in_hs;
    logic              out_hs;
    logic              fifo_wr;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] shaped;

    assign in_hs   = i_tvalid & i_tready;
    assign out_hs  = o_tvalid & o_tready;
    assign fifo_wr = in_hs && (act_mode != MODE_DISCARD);

    sync_fifo_fwft #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (i_tdata),
        .rd_en   (out_hs),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        i_tready = 1'b0;
        o_tvalid = 1'b0;
        if (in_en) begin
            unique case (act_mode)
                MODE_DISCARD: begin
                    i_tready = 1'b1;
                    o_tvalid = ~empty;
                end
                MODE_LINE: begin
                    if (state == ST_COLLECT)
                        i_tready = ~full;
                    else
                        o_tvalid = ~empty;
                end
                default: begin
                    i_tready = ~full;
                    o_tvalid = ~empty;
                end
            endcase
        end
    end

    generate
        if (DATA_W == 8) begin : g_case
            assign shaped = (act_mode == MODE_CASE) ? to_upper(rd_data) : rd_data;
        end else begin : g_nocase
            assign shaped = rd_data;
        end
    endgenerate

    // Zero when idle keeps the reset value and never exposes stale storage.
    assign o_tdata = o_tvalid ? shaped : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_COLLECT;
            act_mode <= MODE_PASS;
            in_en    <= 1'b0;
        end else begin
            in_en <= 1'b1;
            // A byte entering an empty FIFO on this edge starts a line under the current mode.
            if (state == ST_COLLECT && empty && !fifo_wr)
                act_mode <= mode_e'(mode);
            unique case (state)
                ST_COLLECT: begin
                    if (act_mode == MODE_LINE && fifo_wr &&
                        (i_tdata == EOL || level == LW'(DEPTH - 1)))
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (empty || (out_hs && level == LW'(1)))
                        state <= ST_COLLECT;
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_count   <= '0;
            tx_count   <= '0;
            drop_count <= '0;
        end else begin
            if (in_hs && rx_count != '1)
                rx_count <= rx_count + CNT_W'(1);
            if (out_hs && tx_count != '1)
                tx_count <= tx_count + CNT_W'(1);
            if (in_hs && act_mode == MODE_DISCARD && drop_count != '1)
                drop_count <= drop_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_axis_uart_echo_engine.sv
// Directed bench for the echo engine; a scoreboard queue holds the bytes
// expected on the output stream in order.
module tb_axis_uart_echo_engine;
    import uart_echo_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [7:0] i_tdata;
    logic       i_tvalid;
    logic       i_tready;
    logic [7:0] o_tdata;
    logic       o_tvalid;
    logic       o_tready;
    logic [4:0] level;
    logic [15:0] rx_count, tx_count, drop_count;

    logic [1:0] c_mode;
    logic [7:0] c_i_tdata;
    logic       c_i_tvalid, c_i_tready;
    logic [7:0] c_o_tdata;
    logic       c_o_tvalid, c_o_tready;
    logic [4:0] c_level;
    logic [3:0] c_rx_count, c_tx_count, c_drop_count;

    int checks = 0;
    int errors = 0;
    int tb_rx = 0;
    int tb_tx = 0;
    int tb_drop = 0;
    mode_e model_mode = MODE_PASS;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    axis_uart_echo_engine dut (
        .clk(clk), .rst(rst), .mode(mode),
        .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .level(level), .rx_count(rx_count), .tx_count(tx_count), .drop_count(drop_count)
    );

    axis_uart_echo_engine #(.CNT_W(4)) dut_c4 (
        .clk(clk), .rst(rst), .mode(c_mode),
        .i_tdata(c_i_tdata), .i_tvalid(c_i_tvalid), .i_tready(c_i_tready),
        .o_tdata(c_o_tdata), .o_tvalid(c_o_tvalid), .o_tready(c_o_tready),
        .level(c_level), .rx_count(c_rx_count), .tx_count(c_tx_count), .drop_count(c_drop_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] expect_byte(input logic [7:0] b, input mode_e m);
        if (m == MODE_CASE && b >= 8'h61 && b <= 8'h7A)
            return b - 8'h20;
        return b;
    endfunction

    // Output monitor: the handshake seen at a negedge completes on the next posedge.
    always @(negedge clk) begin
        if (!rst && o_tvalid && o_tready) begin
            if (exp_q.size() != 0) begin
                check("out_byte", {24'h0, o_tdata}, {24'h0, exp_q.pop_front()});
                tb_tx++;
            end else begin
                check("out_pending", 32'(exp_q.size() != 0), 32'd1);
            end
        end
    end

    task automatic send(input logic [7:0] b);
        bit ok = 1'b0;
        i_tdata  = b;
        i_tvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i_tready) begin
                ok = 1'b1;
                break;
            end
        end
        check("send_accept", 32'(ok), 32'd1);
        if (ok) begin
            tb_rx++;
            if (model_mode == MODE_DISCARD)
                tb_drop++;
            else
                exp_q.push_back(expect_byte(b, model_mode));
            @(posedge clk);
            #1;
        end
        i_tvalid = 1'b0;
    endtask

    task automatic set_mode(input mode_e m);
        mode       = m;
        model_mode = m;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++)
            @(negedge clk);
        repeat (2) @(posedge clk);
        #1;
        check("drain_queue", exp_q.size(), 0);
        check("drain_level", {27'h0, level}, 0);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_rx"}, {16'h0, rx_count}, tb_rx);
        check({tag, "_tx"}, {16'h0, tx_count}, tb_tx);
        check({tag, "_drop"}, {16'h0, drop_count}, tb_drop);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_in;
        int n_out;
        rst = 1'b1; mode = 2'd0; i_tdata = 8'h00; i_tvalid = 1'b0; o_tready = 1'b1;
        c_mode = 2'd0; c_i_tdata = 8'h00; c_i_tvalid = 1'b0; c_o_tready = 1'b1;
        #23;
        check("rst_i_tready", 32'(i_tready), 0);
        check("rst_o_tvalid", 32'(o_tvalid), 0);
        check("rst_o_tdata", {24'h0, o_tdata}, 0);
        check("rst_level", {27'h0, level}, 0);
        check_counters("rst");
        @(negedge clk); rst = 1'b0;
        check("pre_edge_i_tready", 32'(i_tready), 0);
        @(posedge clk); #1;
        check("first_edge_i_tready", 32'(i_tready), 1);

        // PASS: one-cycle latency, one byte per cycle.
        send(8'h41);
        check("pass_lat_valid", 32'(o_tvalid), 1);
        check("pass_lat_data", {24'h0, o_tdata}, 32'h41);
        send(8'h42);
        check("pass_stream_data", {24'h0, o_tdata}, 32'h42);
        send(8'h43);
        wait_drain();
        check_counters("pass");

        // LINE: held until EOL, then drained with input blocked.
        set_mode(MODE_LINE);
        send(8'h68);
        check("line_hold_h", 32'(o_tvalid), 0);
        send(8'h69);
        check("line_hold_i", 32'(o_tvalid), 0);
        send(8'h0D);
        check("line_first_valid", 32'(o_tvalid), 1);
        check("line_first_data", {24'h0, o_tdata}, 32'h68);
        check("line_drain_block", 32'(i_tready), 0);
        @(posedge clk); #1;
        check("line_second_data", {24'h0, o_tdata}, 32'h69);
        check("line_drain_block2", 32'(i_tready), 0);
        @(posedge clk); #1;
        check("line_eol_data", {24'h0, o_tdata}, 32'h0D);
        @(posedge clk); #1;
        check("line_done_valid", 32'(o_tvalid), 0);
        check("line_collect_ready", 32'(i_tready), 1);

        // LINE overflow flush at DEPTH bytes without EOL.
        for (int i = 0; i < 16; i++) begin
            send(8'h30 + 8'(i));
            if (i == 7)
                check("ovf_mid_hold", 32'(o_tvalid), 0);
        end
        check("ovf_level", {27'h0, level}, 16);
        check("ovf_ready_low", 32'(i_tready), 0);
        check("ovf_valid", 32'(o_tvalid), 1);
        wait_drain();
        check("ovf_ready_back", 32'(i_tready), 1);
        check_counters("line");

        // CASE: lower-case letters only, including both range edges.
        set_mode(MODE_CASE);
        send(8'h61); send(8'h7A); send(8'h5B); send(8'h31); send(8'h60); send(8'h7B);
        wait_drain();

        // DISCARD then switch back to PASS while empty.
        set_mode(MODE_DISCARD);
        for (int i = 0; i < 20; i++)
            send(8'h80 + 8'(i));
        check("disc_no_valid", 32'(o_tvalid), 0);
        check("disc_drop20", {16'h0, drop_count}, 20);
        check_counters("disc");
        set_mode(MODE_PASS);
        send(8'h55);
        check("modechg_valid", 32'(o_tvalid), 1);
        check("modechg_data", {24'h0, o_tdata}, 32'h55);
        wait_drain();
        check_counters("modechg");

        // Backpressure: fill, hold off a 17th byte, then reset mid-stream.
        o_tready = 1'b0;
        for (int i = 0; i < 16; i++)
            send(8'hA0 + 8'(i));
        check("bp_level", {27'h0, level}, 16);
        check("bp_ready", 32'(i_tready), 0);
        check("bp_head", {24'h0, o_tdata}, 32'hA0);
        i_tdata = 8'hFF; i_tvalid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("bp_held_level", {27'h0, level}, 16);
        check("bp_held_rx", {16'h0, rx_count}, tb_rx);
        #2 rst = 1'b1;
        #1;
        check("arst_i_tready", 32'(i_tready), 0);
        check("arst_o_tvalid", 32'(o_tvalid), 0);
        check("arst_o_tdata", {24'h0, o_tdata}, 0);
        check("arst_level", {27'h0, level}, 0);
        tb_rx = 0; tb_tx = 0; tb_drop = 0;
        exp_q.delete();
        check_counters("arst");
        i_tvalid = 1'b0; o_tready = 1'b1; mode = 2'd0; model_mode = MODE_PASS;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        send(8'h12);
        wait_drain();
        check_counters("post_rst");

        // Saturation on the CNT_W=4 instance.
        n_in = 0; n_out = 0;
        c_i_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (c_i_tvalid && c_i_tready) n_in++;
            if (c_o_tvalid && c_o_tready) n_out++;
            @(posedge clk); #1;
            c_i_tdata = c_i_tdata + 8'd1;
        end
        c_i_tvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (c_o_tvalid && c_o_tready) n_out++;
        end
        @(posedge clk); #1;
        check("c4_accepted", n_in, 20);
        check("c4_rx_sat", {28'h0, c_rx_count}, (n_in > 15) ? 15 : n_in);
        check("c4_tx_sat", {28'h0, c_tx_count}, (n_out > 15) ? 15 : n_out);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
